// File: rtl/memory_controller.sv
// memory_controller: sequences byte/half/word/double load and store requests
// byte-serially onto an 8-bit synchronous RAM port and returns raw
// little-endian read data with a one-cycle completion pulse.
module memory_controller #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_start,
  input  logic              sel_mem_operation,
  input  logic [1:0]        sel_mem_size,
  input  logic [63:0]       address,
  input  logic [63:0]       write_data,
  output logic [63:0]       read_data,
  output logic              memory_done,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, TAIL, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [63:0]         acc_q, acc_d;
  logic [63:0]         read_data_q, read_data_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [2:0]          last_idx;
  logic [ADDR_W-1:0]   cur_addr;

  // Insert one byte into a little-endian 64-bit word at byte lane idx.
  function automatic logic [63:0] put_byte(input logic [63:0] w,
                                           input logic [2:0]  idx,
                                           input logic [7:0]  b);
    logic [63:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Index of the final byte of the transfer (N-1) and the current RAM address.
  always_comb begin
    case (size_q)
      2'b00:   last_idx = 3'd0;
      2'b01:   last_idx = 3'd1;
      2'b10:   last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
    cur_addr = addr_q + ADDR_W'(cnt_q);
  end

  // Next-state logic: request acceptance, byte sequencing and read assembly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    read_data_d = read_data_q;
    ram_addr_d  = ram_addr_q;
    case (state_q)
      IDLE: begin
        if (memory_start) begin
          op_d    = sel_mem_operation;
          size_d  = sel_mem_size;
          addr_d  = address[ADDR_W-1:0];
          wdata_d = write_data;
          cnt_d   = 3'd0;
          acc_d   = 64'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_addr_d = cur_addr;
        // Read data lags the strobe by one cycle, so it belongs to byte cnt-1.
        if (!op_q && cnt_q != 3'd0)
          acc_d = put_byte(acc_q, cnt_q - 3'd1, ram_rdata);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == last_idx)
          state_d = op_q ? DONE : TAIL;
      end
      TAIL: begin
        acc_d       = put_byte(acc_q, last_idx, ram_rdata);
        read_data_d = acc_d;
        state_d     = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, result and held RAM address; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      read_data_q <= 64'd0;
      ram_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      ram_addr_q  <= ram_addr_d;
    end
  end

  // Latched request operands and read accumulator; always rewritten on accept.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    acc_q   <= acc_d;
  end

  // Port outputs; the strobe is gated by reset so writes stop on the reset edge.
  always_comb begin
    busy        = (state_q != IDLE);
    memory_done = (state_q == DONE);
    ram_en      = (state_q == ACCESS) && reset;
    ram_we      = ram_en && op_q;
    ram_addr    = ram_en ? cur_addr : ram_addr_q;
    ram_wdata   = ram_en ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;
    read_data   = read_data_q;
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a behavioural 64 KiB byte RAM.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_start;
  logic        sel_mem_operation;
  logic [1:0]  sel_mem_size;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        memory_done;
  logic        busy;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  logic        en_log   [0:31];
  logic        we_log   [0:31];
  logic [15:0] addr_log [0:31];
  logic [7:0]  wd_log   [0:31];
  int          done_cyc;

  memory_controller #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .memory_start(memory_start),
    .sel_mem_operation(sel_mem_operation), .sel_mem_size(sel_mem_size),
    .address(address), .write_data(write_data), .read_data(read_data),
    .memory_done(memory_done), .busy(busy), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: write on enable+we, registered read otherwise.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request in cycle 0, drop start in cycle 1, log until done.
  task automatic run_txn(input logic op, input logic [1:0] sz,
                         input logic [63:0] a, input logic [63:0] wd);
    done_cyc = -1;
    @(posedge clk); #1;
    memory_start = 1'b1; sel_mem_operation = op; sel_mem_size = sz;
    address = a; write_data = wd;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        memory_start = 1'b0;
        address = 64'hDEAD;
        write_data = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      en_log[c] = ram_en; we_log[c] = ram_we;
      addr_log[c] = ram_addr; wd_log[c] = ram_wdata;
      if (memory_done) begin
        done_cyc = c;
        break;
      end
    end
    if (done_cyc < 0) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    chk("done_single_pulse", 64'(memory_done), 64'd0);
  endtask

  initial begin
    logic [63:0] dbl;
    dbl = 64'h1122334455667788;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b0; memory_start = 1'b0; sel_mem_operation = 1'b0;
    sel_mem_size = 2'b00; address = 64'd0; write_data = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(memory_done), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst_read_data", read_data, 64'd0);
    reset = 1'b1;

    // Double write at 0x0010.
    run_txn(1'b1, 2'b11, 64'h0010, dbl);
    chk("wr_dbl_done_cyc", 64'(done_cyc), 64'd9);
    for (int i = 1; i <= 8; i++) begin
      chk("wr_dbl_en", 64'(en_log[i] && we_log[i]), 64'd1);
      chk("wr_dbl_addr", 64'(addr_log[i]), 64'h0010 + 64'(i - 1));
      chk("wr_dbl_wdata", 64'(wd_log[i]), (dbl >> (8 * (i - 1))) & 64'hFF);
    end
    chk("wr_dbl_mem10", 64'(mem[16'h0010]), 64'h88);
    chk("wr_dbl_mem17", 64'(mem[16'h0017]), 64'h11);
    chk("wr_dbl_rd_unchanged", read_data, 64'd0);

    // Double read back.
    run_txn(1'b0, 2'b11, 64'h0010, 64'd0);
    chk("rd_dbl_done_cyc", 64'(done_cyc), 64'd10);
    for (int i = 1; i <= 8; i++) begin
      chk("rd_dbl_en", 64'(en_log[i] && !we_log[i]), 64'd1);
      chk("rd_dbl_addr", 64'(addr_log[i]), 64'h0010 + 64'(i - 1));
    end
    chk("rd_dbl_data", read_data, dbl);

    // Byte then half read.
    run_txn(1'b0, 2'b00, 64'h0013, 64'd0);
    chk("rd_byte_done_cyc", 64'(done_cyc), 64'd3);
    chk("rd_byte_data", read_data, 64'h55);
    run_txn(1'b0, 2'b01, 64'h0011, 64'd0);
    chk("rd_half_done_cyc", 64'(done_cyc), 64'd4);
    chk("rd_half_data", read_data, 64'h6677);

    // Half write wrapping the address space, then read it back.
    run_txn(1'b1, 2'b01, 64'h1_0000_FFFF, 64'hBEEF);
    chk("wr_wrap_done_cyc", 64'(done_cyc), 64'd3);
    chk("wr_wrap_memffff", 64'(mem[16'hFFFF]), 64'hEF);
    chk("wr_wrap_mem0000", 64'(mem[16'h0000]), 64'hBE);
    chk("wr_wrap_rd_held", read_data, 64'h6677);
    run_txn(1'b0, 2'b01, 64'hFFFF, 64'd0);
    chk("rd_wrap_data", read_data, 64'hBEEF);

    // Reset asserted in cycle 4 of a double write.
    @(posedge clk); #1;
    memory_start = 1'b1; sel_mem_operation = 1'b1; sel_mem_size = 2'b11;
    address = 64'h0100; write_data = 64'hA8A7A6A5A4A3A2A1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      memory_start = 1'b0;
      if (c == 4) reset = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(memory_done), 64'd0);
    chk("mid_rst_ram_en", 64'(ram_en), 64'd0);
    chk("mid_rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("mid_rst_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("mid_rst_read_data", read_data, 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", 64'(memory_done), 64'd0);
    end
    chk("mid_rst_mem100", 64'(mem[16'h0100]), 64'hA1);
    chk("mid_rst_mem102", 64'(mem[16'h0102]), 64'hA3);
    chk("mid_rst_mem103", 64'(mem[16'h0103]), 64'h00);

    // memory_start held high: back-to-back word reads.
    @(posedge clk); #1;
    memory_start = 1'b1; sel_mem_operation = 1'b0; sel_mem_size = 2'b10;
    address = 64'h0010;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 2) address = 64'h0014;
      chk("b2b_done", 64'(memory_done), 64'((c == 6) || (c == 13)));
      chk("b2b_busy", 64'(busy), 64'(!((c == 7) || (c == 14))));
      if (c == 6) chk("b2b_first_data", read_data, 64'h55667788);
      if (c == 13) chk("b2b_second_data", read_data, 64'h11223344);
    end
    memory_start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
